// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed-bus controller: refresh-driven 9-register read bursts,
// single buffered writes, and registered BCD time/date/timer outputs.
module rtc_bus_ctrl #(
  parameter int unsigned T_PHASE        = 10,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a_d,
  output logic [23:0] time_bcd,
  output logic [23:0] date_bcd,
  output logic [23:0] timer_bcd,
  output logic        busy,
  output logic        read_done
);

  localparam int unsigned    RW        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0]  REF_LAST  = RW'(REFRESH_CYCLES - 1);
  localparam logic [7:0]     PH_LAST   = 8'(T_PHASE - 1);
  localparam logic [3:0]     LAST_READ = 4'd8;

  typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, RECOV} state_t;

  state_t      state, state_next;
  logic [7:0]  phase_cnt;
  logic [RW-1:0] refresh_cnt;
  logic        read_pending, write_pending;
  logic [7:0]  wb_addr, wb_data;
  logic [7:0]  cur_addr, cur_data;
  logic        is_write;
  logic [3:0]  burst_idx;
  logic [7:0]  shadow [0:7];

  logic        wrap, phase_last;
  logic        start_write, start_read;
  logic        sample, burst_next, write_end;

  function automatic logic [7:0] burst_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    burst_addr = 8'h21;
      4'd1:    burst_addr = 8'h22;
      4'd2:    burst_addr = 8'h23;
      4'd3:    burst_addr = 8'h24;
      4'd4:    burst_addr = 8'h25;
      4'd5:    burst_addr = 8'h26;
      4'd6:    burst_addr = 8'h41;
      4'd7:    burst_addr = 8'h42;
      4'd8:    burst_addr = 8'h43;
      default: burst_addr = 8'h21;
    endcase
  endfunction

  assign wrap       = (refresh_cnt == REF_LAST);
  assign phase_last = (phase_cnt == PH_LAST);
  assign sample     = (state == DATA) && phase_last && !is_write;
  assign burst_next = (state == RECOV) && phase_last && !is_write && (burst_idx != LAST_READ);
  assign write_end  = (state == RECOV) && phase_last && is_write;
  assign busy       = (state != IDLE) || write_pending || read_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Idle arbitration also looks at this cycle's wr_req/wrap so a request
  // seen in IDLE starts its transaction on the very next edge.
  always_comb begin
    state_next  = state;
    start_write = 1'b0;
    start_read  = 1'b0;
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    a_d         = 1'b0;
    ad_oe       = 1'b0;
    ad_out      = '0;
    unique case (state)
      IDLE: begin
        if (write_pending || wr_req) begin
          state_next  = ADDR;
          start_write = 1'b1;
        end else if (read_pending || wrap) begin
          state_next = ADDR;
          start_read = 1'b1;
        end
      end
      ADDR: begin
        cs_n   = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = cur_addr;
        if (phase_last) state_next = GAP;
      end
      GAP: begin
        if (phase_last) state_next = DATA;
      end
      DATA: begin
        cs_n = 1'b0;
        a_d  = 1'b1;
        if (is_write) begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = cur_data;
        end else begin
          rd_n = 1'b0;
        end
        if (phase_last) state_next = RECOV;
      end
      RECOV: begin
        if (phase_last) state_next = burst_next ? ADDR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt   <= '0;
      refresh_cnt <= '0;
    end else begin
      phase_cnt   <= (state == IDLE || phase_last) ? '0 : phase_cnt + 8'd1;
      refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_pending  <= 1'b0;
      write_pending <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      cur_addr      <= '0;
      cur_data      <= '0;
      is_write      <= 1'b0;
      burst_idx     <= '0;
    end else begin
      read_pending <= (read_pending || wrap) && !start_read;
      if (write_end)   write_pending <= 1'b0;
      else if (wr_req) write_pending <= 1'b1;
      if (wr_req && !write_pending) begin
        wb_addr <= wr_addr;
        wb_data <= wr_data;
      end
      if (start_write) begin
        is_write <= 1'b1;
        cur_addr <= write_pending ? wb_addr : wr_addr;
        cur_data <= write_pending ? wb_data : wr_data;
      end else if (start_read) begin
        is_write  <= 1'b0;
        burst_idx <= '0;
        cur_addr  <= burst_addr(4'd0);
      end else if (burst_next) begin
        burst_idx <= burst_idx + 4'd1;
        cur_addr  <= burst_addr(burst_idx + 4'd1);
      end
    end
  end

  // The ninth byte goes straight from ad_in to the outputs, so all three
  // BCD words change together one cycle after the final sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_bcd  <= '0;
      date_bcd  <= '0;
      timer_bcd <= '0;
      read_done <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) shadow[i] <= '0;
    end else begin
      read_done <= 1'b0;
      if (sample) begin
        if (burst_idx == LAST_READ) begin
          time_bcd  <= {shadow[2], shadow[1], shadow[0]};
          date_bcd  <= {shadow[3], shadow[4], shadow[5]};
          timer_bcd <= {ad_in, shadow[7], shadow[6]};
          read_done <= 1'b1;
        end else begin
          shadow[burst_idx[2:0]] <= ad_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: transaction-timeline reference model, RTC memory
// model on the bus, directed scenarios plus randomized write traffic.
module tb_rtc_bus_ctrl;
  localparam int T = 4;
  localparam int R = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req;
  logic [7:0]  wr_addr, wr_data, ad_in, ad_out;
  logic        ad_oe, cs_n, rd_n, wr_n, a_d, busy, read_done;
  logic [23:0] time_bcd, date_bcd, timer_bcd;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_PHASE(T), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_d(a_d), .time_bcd(time_bcd), .date_bcd(date_bcd), .timer_bcd(timer_bcd),
    .busy(busy), .read_done(read_done)
  );

  // RTC chip model: latches the address phase, answers reads, stores writes
  logic [7:0] rtc_mem [256];
  logic [7:0] bus_addr;
  assign ad_in = rtc_mem[bus_addr];

  logic [7:0] ref_mem [256];
  logic [7:0] burst_tab [9];

  int total = 0, bad = 0;
  int pin_err = 0, width_err = 0, ovl_err = 0, oe_err = 0, notes = 0;
  int done_cnt = 0, exp_bursts = 0, rd_strobes = 0, rd_run = 0, wr_run = 0, cyc = 0;

  // Reference model: a transaction is a start point plus elapsed cycles
  bit          m_active, m_write, m_wp, m_rp;
  int          m_t, m_k, m_ref;
  logic [7:0]  m_addr, m_data, m_wb_addr, m_wb_data;
  logic [7:0]  m_sh [9];
  logic [23:0] e_time, e_date, e_timer;
  logic        e_done;

  task automatic model_reset();
    m_active = 0; m_write = 0; m_wp = 0; m_rp = 0;
    m_t = 0; m_k = 0; m_ref = 0;
    m_addr = '0; m_data = '0; m_wb_addr = '0; m_wb_data = '0;
    for (int i = 0; i < 9; i++) m_sh[i] = '0;
    e_time = '0; e_date = '0; e_timer = '0; e_done = 1'b0;
    rd_run = 0; wr_run = 0;
  endtask

  task automatic step(input bit req, input logic [7:0] a, input logic [7:0] d);
    logic e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, next_done;
    logic [7:0] e_out;
    bit wrap, st_read, wp_clr;
    wr_req = req; wr_addr = a; wr_data = d;
    e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 0; e_oe = 0; e_out = '0;
    if (m_active) begin
      case (m_t / T)
        0: begin e_cs = 0; e_wr = 0; e_oe = 1; e_out = m_addr; end
        2: begin
          e_cs = 0; e_ad = 1;
          if (m_write) begin e_wr = 0; e_oe = 1; e_out = m_data; end
          else e_rd = 0;
        end
        default: ;
      endcase
    end
    e_busy = m_active | m_wp | m_rp;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, busy, read_done} !==
        {e_cs, e_rd, e_wr, e_ad, e_oe, e_out, e_busy, e_done} ||
        {time_bcd, date_bcd, timer_bcd} !== {e_time, e_date, e_timer}) begin
      pin_err++;
      if (notes < 6) begin
        notes++;
        $display("  note: cycle %0d pins=%h bcd=%h want pins=%h bcd=%h", cyc,
          {cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, busy, read_done}, {time_bcd, date_bcd, timer_bcd},
          {e_cs, e_rd, e_wr, e_ad, e_oe, e_out, e_busy, e_done}, {e_time, e_date, e_timer});
      end
    end
    if (!rd_n && !wr_n) ovl_err++;
    if (!rd_n && ad_oe) oe_err++;
    if (!rd_n) rd_run++;
    else begin
      if (rd_run != 0) begin rd_strobes++; if (rd_run != T) width_err++; end
      rd_run = 0;
    end
    if (!wr_n) wr_run++;
    else begin
      if (wr_run != 0 && wr_run != T) width_err++;
      wr_run = 0;
    end
    if (read_done) done_cnt++;
    if (!cs_n && !a_d && !wr_n && ad_oe) bus_addr = ad_out;
    if (!cs_n && a_d && !wr_n && ad_oe) rtc_mem[bus_addr] = ad_out;

    wrap = (m_ref == R - 1); st_read = 0; wp_clr = 0; next_done = 0;
    if (m_active) begin
      if (m_t == 3 * T - 1) begin
        if (m_write) ref_mem[m_addr] = m_data;
        else begin
          m_sh[m_k] = ref_mem[m_addr];
          if (m_k == 8) begin
            e_time  = {m_sh[2], m_sh[1], m_sh[0]};
            e_date  = {m_sh[3], m_sh[4], m_sh[5]};
            e_timer = {m_sh[8], m_sh[7], m_sh[6]};
            next_done = 1;
          end
        end
      end
      if (m_t == 4 * T - 1) begin
        m_t = 0;
        if (m_write) begin wp_clr = 1; m_active = 0; end
        else if (m_k < 8) begin m_k++; m_addr = burst_tab[m_k]; end
        else m_active = 0;
      end else m_t++;
    end else if (m_wp || req) begin
      m_active = 1; m_write = 1; m_t = 0;
      m_addr = m_wp ? m_wb_addr : a;
      m_data = m_wp ? m_wb_data : d;
    end else if (m_rp || wrap) begin
      m_active = 1; m_write = 0; m_t = 0; m_k = 0; m_addr = burst_tab[0]; st_read = 1;
    end
    if (req && !m_wp) begin m_wb_addr = a; m_wb_data = d; end
    m_wp = wp_clr ? 0 : (m_wp | req);
    m_rp = (m_rp | wrap) & !st_read;
    m_ref = wrap ? 0 : m_ref + 1;
    e_done = next_done;
    if (next_done) exp_bursts++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
    rtc_mem[a] = v; ref_mem[a] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; bus_addr = '0;
    for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom_range(0, 255)));
    burst_tab = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    repeat (2) @(negedge clk);
    wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h33;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    total++; if ({cs_n, rd_n, wr_n} !== 3'b111) begin bad++; $display("FAIL reset_strobes got=%b want=111", {cs_n, rd_n, wr_n}); end
    total++; if ({a_d, ad_oe, ad_out} !== 10'h000) begin bad++; $display("FAIL reset_bus got=%h want=000", {a_d, ad_oe, ad_out}); end
    total++; if ({time_bcd, date_bcd, timer_bcd} !== 72'h0) begin bad++; $display("FAIL reset_bcd got=%h want=0", {time_bcd, date_bcd, timer_bcd}); end
    total++; if ({busy, read_done} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", {busy, read_done}); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_refresh_burst();
    int d0, s0;
    logic [7:0] vals [9];
    vals = '{8'h59, 8'h30, 8'h12, 8'h25, 8'h04, 8'h16, 8'h05, 8'h02, 8'h01};
    for (int i = 0; i < 9; i++) set_mem(burst_tab[i], vals[i]);
    d0 = done_cnt; s0 = rd_strobes;
    idle(R + 9 * 4 * T + 4);
    total++; if (time_bcd !== 24'h123059) begin bad++; $display("FAIL burst_time got=%h want=123059", time_bcd); end
    total++; if (date_bcd !== 24'h250416) begin bad++; $display("FAIL burst_date got=%h want=250416", date_bcd); end
    total++; if (timer_bcd !== 24'h010205) begin bad++; $display("FAIL burst_timer got=%h want=010205", timer_bcd); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL burst_done_pulses got=%0d want=1", done_cnt - d0); end
    total++; if (rd_strobes - s0 !== 9) begin bad++; $display("FAIL burst_reads got=%0d want=9", rd_strobes - s0); end
    total++; if (pin_err !== 0) begin bad++; $display("FAIL burst_timeline got=%0d want=0 mismatching cycles", pin_err); end
  endtask

  task automatic test_write();
    int bcnt, rdlow, n;
    logic [17:0] aseen, dseen;
    n = 0;
    while ((m_ref > R - 30 || m_active || m_wp || m_rp) && n < 1000) begin idle(1); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL write_wait_idle got=timeout want=idle"); end
    step(1'b1, 8'h22, 8'h45);
    bcnt = 0; rdlow = 0; aseen = '0; dseen = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)     aseen = {ad_out, wr_n, a_d, ad_oe, rd_n, 6'h0};
      if (i == 2 * T) dseen = {ad_out, wr_n, a_d, ad_oe, rd_n, 6'h0};
      if (busy) bcnt++;
      if (!rd_n) rdlow++;
      idle(1);
    end
    total++; if (aseen !== {8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 6'h0}) begin bad++; $display("FAIL write_addr_phase got=%h want=%h", aseen, {8'h22, 4'b0011, 6'h0}); end
    total++; if (dseen !== {8'h45, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0}) begin bad++; $display("FAIL write_data_phase got=%h want=%h", dseen, {8'h45, 4'b0111, 6'h0}); end
    total++; if (bcnt !== 4 * T) begin bad++; $display("FAIL write_busy_len got=%0d want=%0d", bcnt, 4 * T); end
    total++; if (rdlow !== 0) begin bad++; $display("FAIL write_rd_quiet got=%0d want=0", rdlow); end
    total++; if (rtc_mem[8'h22] !== 8'h45) begin bad++; $display("FAIL write_stored got=%h want=45", rtc_mem[8'h22]); end
    total++; if (pin_err !== 0) begin bad++; $display("FAIL write_timeline got=%0d want=0", pin_err); end
  endtask

  task automatic test_write_during_burst();
    int n, s0, cyc_done, cyc_w;
    logic [7:0] a1, a2, d1, d2, old2;
    n = 0;
    while (!(m_active && !m_write && m_k == 2 && m_t == T) && n < 1000) begin idle(1); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL wdb_wait_read3 got=timeout want=read3"); end
    a1 = 8'($urandom_range(0, 15)); a2 = a1 + 8'd16;
    d1 = 8'($urandom_range(0, 255)); old2 = rtc_mem[a2]; d2 = ~old2;
    s0 = rd_strobes; cyc_done = -1; cyc_w = -1;
    step(1'b1, a1, d1);
    idle(5);
    step(1'b1, a2, d2);
    n = 0;
    while ((m_active || m_wp || m_rp) && n < 1000) begin
      if (read_done && cyc_done < 0) cyc_done = cyc;
      if (cyc_done >= 0 && cyc_w < 0 && !cs_n && !wr_n && !a_d) cyc_w = cyc;
      idle(1); n++;
    end
    total++; if (n >= 1000) begin bad++; $display("FAIL wdb_wait_end got=timeout want=idle"); end
    total++; if (rd_strobes - s0 !== 7) begin bad++; $display("FAIL wdb_reads_uninterrupted got=%0d want=7", rd_strobes - s0); end
    total++; if (cyc_w - cyc_done !== T + 1) begin bad++; $display("FAIL wdb_write_follows got=%0d want=%0d", cyc_w - cyc_done, T + 1); end
    total++; if (rtc_mem[a1] !== d1) begin bad++; $display("FAIL wdb_first_write got=%h want=%h", rtc_mem[a1], d1); end
    total++; if (rtc_mem[a2] !== old2) begin bad++; $display("FAIL wdb_second_ignored got=%h want=%h", rtc_mem[a2], old2); end
    total++; if (pin_err !== 0) begin bad++; $display("FAIL wdb_timeline got=%0d want=0", pin_err); end
  endtask

  task automatic test_simultaneous();
    int n, d0;
    logic [7:0] a, d;
    n = 0;
    while (!(m_ref == R - 1 && !m_active && !m_wp && !m_rp) && n < 1000) begin idle(1); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL sim_wait got=timeout want=idle_at_wrap"); end
    a = 8'($urandom_range(0, 31)); d = 8'($urandom_range(0, 255));
    d0 = done_cnt;
    step(1'b1, a, d);
    total++; if ({ad_out, wr_n, a_d} !== {a, 2'b00}) begin bad++; $display("FAIL sim_write_first got=%h want=%h", {ad_out, wr_n, a_d}, {a, 2'b00}); end
    idle(4 * T);
    total++; if ({cs_n, busy} !== 2'b11) begin bad++; $display("FAIL sim_idle_pending got=%b want=11", {cs_n, busy}); end
    idle(1);
    total++; if ({ad_out, wr_n, a_d} !== {8'h21, 2'b00}) begin bad++; $display("FAIL sim_burst_next got=%h want=%h", {ad_out, wr_n, a_d}, {8'h21, 2'b00}); end
    idle(9 * 4 * T);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL sim_burst_done got=%0d want=1", done_cnt - d0); end
    total++; if (pin_err !== 0) begin bad++; $display("FAIL sim_timeline got=%0d want=0", pin_err); end
  endtask

  task automatic test_reset_mid_burst();
    int n, d0;
    logic [71:0] want;
    for (int i = 0; i < 9; i++) set_mem(burst_tab[i], 8'($urandom_range(0, 255)));
    n = 0;
    while (!(m_active && !m_write && m_k == 4 && m_t == 2 * T + 1) && n < 1000) begin idle(1); n++; end
    total++; if (n >= 1000 || rd_n !== 1'b0) begin bad++; $display("FAIL rst_reach_read5 got=%0d/%b want=read5 strobe", n, rd_n); end
    #2 reset = 1'b1;
    #1;
    total++; if ({cs_n, rd_n, ad_oe} !== 3'b110) begin bad++; $display("FAIL rst_async_release got=%b want=110", {cs_n, rd_n, ad_oe}); end
    total++; if ({time_bcd, date_bcd, timer_bcd} !== 72'h0) begin bad++; $display("FAIL rst_async_bcd got=%h want=0", {time_bcd, date_bcd, timer_bcd}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    d0 = done_cnt;
    idle(R + 9 * 4 * T + 4);
    want = {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h24], ref_mem[8'h25], ref_mem[8'h26],
            ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41]};
    total++; if ({time_bcd, date_bcd, timer_bcd} !== want) begin bad++; $display("FAIL rst_next_burst got=%h want=%h", {time_bcd, date_bcd, timer_bcd}, want); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rst_done_once got=%0d want=1", done_cnt - d0); end
    total++; if (pin_err !== 0) begin bad++; $display("FAIL rst_timeline got=%0d want=0", pin_err); end
  endtask

  task automatic test_random();
    int d0, e0;
    d0 = done_cnt; e0 = exp_bursts;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    total++; if (pin_err !== 0) begin bad++; $display("FAIL rand_timeline got=%0d want=0", pin_err); end
    total++; if (done_cnt - d0 !== exp_bursts - e0) begin bad++; $display("FAIL rand_bursts got=%0d want=%0d", done_cnt - d0, exp_bursts - e0); end
    total++; if (ovl_err !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", ovl_err); end
    total++; if (oe_err !== 0) begin bad++; $display("FAIL oe_during_read got=%0d want=0", oe_err); end
    total++; if (width_err !== 0) begin bad++; $display("FAIL strobe_width got=%0d want=0", width_err); end
  endtask

  initial begin
    test_reset();
    test_refresh_burst();
    test_write();
    test_write_during_burst();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
